// File: rtl/instrq_wr_skid.sv
// instrq_wr_skid
//   Two-entry in-order skid buffer between fetch/decode and the instruction
//   queue write port. Bundles are accepted on in_valid & in_ready and are
//   presented on write_* from registered head storage one or more cycles
//   later. The queue consumes the head on write_wen & ~doFStall. An
//   exception flushes every stored bundle (and a same-cycle push) that
//   belongs to except_thread; the survivors keep their order.
//
//   Optional feature macro: INSTRQ_WR_MASKCHK_EN
//     When defined, a non-contiguous in_instrEn is truncated to its run of
//     ones starting at bit 0, and the sticky mask_err output reports it.
//     When undefined, masks are stored as given and mask_err is absent.
//
//   Ports
//     clk, rst                 clock, asynchronous active-low reset
//     in_valid/in_ready        upstream handshake
//     in_thread, in_instrEn    bundle thread and slot-enable mask
//     in_instr, in_other       16 slots of instruction / side-band data
//     except, except_thread    flush request and the thread to flush
//     doFStall                 downstream queue-full stall
//     write_wen .. write_other0  head bundle toward the queue
//     stall_cnt                saturating count of stalled valid cycles
//     mask_err                 (macro only) sticky mask truncation flag

`ifndef instrQ_width
`define instrQ_width 8
`endif

module instrq_wr_skid #(
  parameter int OTHER = `instrQ_width,
  parameter int WIDTH = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_thread,
  input  logic [15:0]           in_instrEn,
  input  logic [16*WIDTH-1:0]   in_instr,
  input  logic [16*OTHER-1:0]   in_other,
  input  logic                  except,
  input  logic                  except_thread,
  input  logic                  doFStall,
  output logic                  write_wen,
  output logic                  write_thread,
  output logic [15:0]           write_instrEn,
  output logic [16*WIDTH-1:0]   write_instr0,
  output logic [16*OTHER-1:0]   write_other0,
  output logic [15:0]           stall_cnt
`ifdef INSTRQ_WR_MASKCHK_EN
  ,
  output logic                  mask_err
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // slot0 is always the head; slot1 is only meaningful in state TWO
  logic                slot0_thr_reg, slot1_thr_reg;
  logic [15:0]         slot0_en_reg, slot1_en_reg;
  logic [16*WIDTH-1:0] slot0_instr_reg, slot1_instr_reg;
  logic [16*OTHER-1:0] slot0_other_reg, slot1_other_reg;
  logic [15:0]         stall_cnt_reg;

  logic        has0, has1;
  logic        kill0, kill1, pop, keep0, keep1, push;
  logic        ld0_from1, ld0_from_in, ld1_from_in;
  logic [1:0]  count_next;
  logic [15:0] mask_store;

`ifdef INSTRQ_WR_MASKCHK_EN
  logic mask_err_reg;
  // x & ~(x+1) keeps exactly the trailing run of ones
  assign mask_store = in_instrEn & ~(in_instrEn + 16'd1);
`else
  assign mask_store = in_instrEn;
`endif

  assign has0 = (state_reg != EMPTY);
  assign has1 = (state_reg == TWO);

  // A flushed head is discarded, never handed to the queue.
  assign kill0 = except & has0 & (slot0_thr_reg == except_thread);
  assign kill1 = except & has1 & (slot1_thr_reg == except_thread);
  assign pop   = has0 & ~doFStall & ~kill0;
  assign keep0 = has0 & ~pop & ~kill0;
  assign keep1 = has1 & ~kill1;
  assign push  = in_valid & in_ready & (|in_instrEn)
               & ~(except & (in_thread == except_thread));

  // Survivors compact toward slot0, then the new bundle lands behind them.
  // keep0 & keep1 implies TWO, where in_ready=0, so the sum never exceeds 2.
  assign ld0_from1   = ~keep0 & keep1;
  assign ld0_from_in = ~keep0 & ~keep1 & push;
  assign ld1_from_in = (keep0 ^ keep1) & push;
  assign count_next  = {1'b0, keep0} + {1'b0, keep1} + {1'b0, push};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= EMPTY;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = EMPTY;
    case (count_next)
      2'd1:    state_next = ONE;
      2'd2:    state_next = TWO;
      default: state_next = EMPTY;
    endcase
  end

  // Output logic: everything comes from registered state and head storage
  always_comb begin
    write_wen     = has0;
    in_ready      = ~has1;
    write_thread  = has0 ? slot0_thr_reg : 1'b0;
    write_instrEn = has0 ? slot0_en_reg : 16'd0;
    write_instr0  = has0 ? slot0_instr_reg : '0;
    write_other0  = has0 ? slot0_other_reg : '0;
    stall_cnt     = stall_cnt_reg;
  end

  // Control fields of the slots carry a reset so write_* are clean at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0_thr_reg <= 1'b0;
      slot0_en_reg  <= 16'd0;
      slot1_thr_reg <= 1'b0;
      slot1_en_reg  <= 16'd0;
    end else begin
      if (ld0_from1) begin
        slot0_thr_reg <= slot1_thr_reg;
        slot0_en_reg  <= slot1_en_reg;
      end else if (ld0_from_in) begin
        slot0_thr_reg <= in_thread;
        slot0_en_reg  <= mask_store;
      end
      if (ld1_from_in) begin
        slot1_thr_reg <= in_thread;
        slot1_en_reg  <= mask_store;
      end
    end
  end

  // Wide payload is left unreset; it is masked to zero while EMPTY
  always_ff @(posedge clk) begin
    if (ld0_from1) begin
      slot0_instr_reg <= slot1_instr_reg;
      slot0_other_reg <= slot1_other_reg;
    end else if (ld0_from_in) begin
      slot0_instr_reg <= in_instr;
      slot0_other_reg <= in_other;
    end
    if (ld1_from_in) begin
      slot1_instr_reg <= in_instr;
      slot1_other_reg <= in_other;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_reg <= 16'd0;
    else if (has0 & doFStall & (stall_cnt_reg != 16'hFFFF))
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

`ifdef INSTRQ_WR_MASKCHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      mask_err_reg <= 1'b0;
    else if (push & (mask_store != in_instrEn))
      mask_err_reg <= 1'b1;
  end
  assign mask_err = mask_err_reg;
`endif

endmodule

// File: doc/instrq_wr_skid.md
INSTRQ_WR_SKID -- requirements
Module: instrq_wr_skid

Interface
REQ-001 SHALL have parameter OTHER, default `instrQ_width, giving the width of per-slot side-band data.
REQ-002 SHALL have parameter WIDTH, default 80, giving the width of the per-slot instruction.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port in_valid, input, 1, fetch/decode bundle offered.
REQ-006 SHALL have port in_ready, output, 1, bundle accepted when in_valid&in_ready.
REQ-007 SHALL have port in_thread, input, 1, thread of the offered bundle.
REQ-008 SHALL have port in_instrEn, input, 16, slot-enable mask, contiguous from bit 0.
REQ-009 SHALL have port in_instr, input, 16xWIDTH, slot instructions.
REQ-010 SHALL have port in_other, input, 16xOTHER, slot side-band data.
REQ-011 SHALL have port except, input, 1, flush request.
REQ-012 SHALL have port except_thread, input, 1, thread being flushed.
REQ-013 SHALL have port doFStall, input, 1, queue-full stall from the downstream instruction queue.
REQ-014 SHALL have port write_wen, output, 1, head bundle valid toward the queue.
REQ-015 SHALL have port write_thread, output, 1, head bundle thread.
REQ-016 SHALL have port write_instrEn, output, 16, head bundle mask.
REQ-017 SHALL have port write_instr0, output, 16xWIDTH, head bundle instructions.
REQ-018 SHALL have port write_other0, output, 16xOTHER, head bundle side-band data.
REQ-019 SHALL have port stall_cnt, output, 16, saturating count of stalled cycles.

Function
REQ-020 SHALL hold bundles in a two-entry in-order FIFO whose occupancy state is EMPTY, ONE or TWO.
REQ-021 SHALL drive all write_* outputs from registered head-entry storage only, with no combinational path from the in_* ports.
REQ-022 SHALL assert write_wen iff state!=EMPTY.
REQ-023 SHALL drive in_ready = (state!=TWO) as a function of registered state only, with no path from doFStall.
REQ-024 SHALL pop the head entry on a cycle with write_wen & ~doFStall; a popped bundle is consumed by the queue in that same cycle.
REQ-025 SHALL push on in_valid & in_ready & |in_instrEn; an accepted all-zero mask is dropped without storage.
REQ-026 SHALL present a pushed bundle on write_* no earlier than the cycle after acceptance (minimum latency 1).
REQ-027 SHALL perform a simultaneous push and pop in state ONE such that state stays ONE and the new bundle becomes the head.
REQ-028 SHALL, on a doFStall cycle, hold the head and all write_* outputs stable.
REQ-029 SHALL, on except, discard every stored entry with thread==except_thread and compact survivors in original order.
REQ-030 SHALL, on except, not pop a head entry whose thread matches except_thread.
REQ-031 SHALL, on except, drop a same-cycle push whose in_thread==except_thread.
REQ-032 SHALL, on except, still perform a same-cycle pop of a non-matching head normally.
REQ-033 SHALL increment stall_cnt on each cycle with write_wen & doFStall, saturating at 16'hFFFF.

Reset
REQ-034 SHALL, while rst=0, force state=EMPTY, write_wen=0, write_instrEn=0, write_thread=0, stall_cnt=0, and in_ready=1 one settle after assertion.
REQ-035 SHALL leave stored payload registers undefined-but-masked while rst=0, with write_instr0 and write_other0 driven 0 while EMPTY.
REQ-036 SHALL treat reset asserted mid-transfer as abandoning stored bundles without a pop.

Configuration
REQ-037 SHALL, with INSTRQ_WR_MASKCHK_EN defined, truncate a non-contiguous in_instrEn to its run of ones starting at bit 0 before storage.
REQ-038 SHALL, with INSTRQ_WR_MASKCHK_EN defined, set a sticky output mask_err (1 bit, cleared only by reset) on truncation.
REQ-039 SHALL, without INSTRQ_WR_MASKCHK_EN defined, store the mask unmodified and omit the mask_err port.

Verification
REQ-040 SHALL verify: after reset, push mask 16'h00FF thread 0 -> next cycle write_wen=1, write_instrEn=16'h00FF, write_thread=0.
REQ-041 SHALL verify: hold doFStall=1, push 3 bundles -> 2 accepted, in_ready=0, outputs stable, stall_cnt counts cycles.
REQ-042 SHALL verify: FIFO holds thread0 then thread1, except with except_thread=0 -> next cycle head is the thread1 bundle, state ONE.
REQ-043 SHALL verify: state ONE with no stall plus push each cycle -> one bundle per cycle delivered in order, no drops.
REQ-044 SHALL verify: with the macro defined, push mask 16'h00F5 -> stored 16'h0001, mask_err=1; without the macro, stored 16'h00F5.
REQ-045 SHALL verify: assert rst=0 in state TWO -> write_wen=0 and stall_cnt=0 immediately, EMPTY after release.
